alu_share_arbiter: RTL and testbench

- Shares one external 16-bit combinational ALU among NREQ requesters.
- Each requester issues opcode plus operands over a valid/ready request channel and gets the result back on a per-requester valid/ready response channel.
- Arbitration is round-robin. One operation is in flight at a time.
- Sits between client blocks and the ALU; the arbiter drives every ALU input.

---
 rtl/alu_share_arbiter_pkg.sv | 23 ++
 rtl/alu_share_arbiter_if.sv | 46 ++++
 rtl/alu_share_arbiter_rr_arbiter.sv | 31 +++
 rtl/alu_share_arbiter.sv | 121 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared opcode/FSM types and default widths for the ALU share arbiter.
package alu_pkg;

  localparam int DW_DEF         = 16;
  localparam int OPW_DEF        = 3;
  localparam int ILLEGAL_OP_MIN = 6;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels between the clients and the ALU share arbiter.
// With ALU_OPCODE_CHECK_EN defined the response channel also carries resp_err.
interface alu_share_arbiter_if
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEF,
  parameter int OPW  = OPW_DEF
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*OPW-1:0] req_opcode;
  logic [NREQ*DW-1:0]  req_a;
  logic [NREQ*DW-1:0]  req_b;
  logic [NREQ-1:0]     resp_valid;
  logic [NREQ-1:0]     resp_ready;
  logic [DW-1:0]       resp_data;
  logic [IW-1:0]       resp_id;

`ifdef ALU_OPCODE_CHECK_EN
  logic                resp_err;

  modport master (
    output req_valid, req_opcode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id, resp_err
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id, resp_err
  );
`else
  modport master (
    output req_valid, req_opcode, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_id
  );

  modport slave (
    input  req_valid, req_opcode, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_data, resp_id
  );
`endif

endinterface

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  always_comb begin : search
    int j;
    // NOTE: every output gets a default before the search so no latch is inferred.
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU among NREQ requesters, one op in flight.
// Define ALU_OPCODE_CHECK_EN to add resp_err and force the result of opcodes 110/111 to 0.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = DW_DEF,
  parameter int OPW  = OPW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_share_arbiter_if.slave bus,
  output logic [OPW-1:0]     alu_opcode,
  output logic [DW-1:0]      alu_a,
  output logic [DW-1:0]      alu_b,
  input  logic [DW-1:0]      alu_result
);

  localparam int IW = $clog2(NREQ);

  state_e          state;
  state_e          state_nxt;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   grant_id;
  logic [NREQ-1:0] grant_vec;
  logic            grant_any;
  logic            resp_hs;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_data;
  logic [DW-1:0]   data_exec;
  logic [OPW-1:0]  op_sel;
  logic [DW-1:0]   a_sel;
  logic [DW-1:0]   b_sel;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (grant_vec),
    .idx (grant_id),
    .any (grant_any)
  );

  assign op_sel = bus.req_opcode[grant_id*OPW +: OPW];
  assign a_sel  = bus.req_a[grant_id*DW +: DW];
  assign b_sel  = bus.req_b[grant_id*DW +: DW];

  // rst_n is active-high here; the grant is masked so no handshake completes in reset.
  always_comb begin
    state_nxt      = state;
    bus.req_ready  = '0;
    bus.resp_valid = '0;
    resp_hs        = 1'b0;
    case (state)
      IDLE: begin
        if (grant_any) begin
          bus.req_ready = rst_n ? '0 : grant_vec;
          state_nxt     = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        bus.resp_valid[resp_id] = 1'b1;
        resp_hs                 = bus.resp_ready[resp_id];
        if (resp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ALU_OPCODE_CHECK_EN
  logic op_illegal;
  logic resp_err;

  assign op_illegal = (alu_opcode >= OPW'(ILLEGAL_OP_MIN));
  assign data_exec  = op_illegal ? '0 : alu_result;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)               resp_err <= 1'b0;
    else if (state == EXEC)  resp_err <= op_illegal;
    else if (resp_hs)        resp_err <= 1'b0;
  end

  assign bus.resp_err = resp_err;
`else
  assign data_exec = alu_result;
`endif

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= IDLE;
      ptr        <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
      alu_opcode <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant_any) begin
            alu_opcode <= op_sel;
            alu_a      <= a_sel;
            alu_b      <= b_sel;
            resp_id    <= grant_id;
          end
        end
        EXEC: resp_data <= data_exec;
        RESP: begin
          if (resp_hs) ptr <= (resp_id == IW'(NREQ - 1)) ? '0 : resp_id + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_data = resp_data;
  assign bus.resp_id   = resp_id;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter with a behavioural ALU.
module tb_alu_share_arbiter;
  import alu_pkg::*;

  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int OPW  = 3;

  logic          clk;
  logic          rst_n;
  logic [OPW-1:0] alu_opcode;
  logic [DW-1:0]  alu_a;
  logic [DW-1:0]  alu_b;
  logic [DW-1:0]  alu_result;

  int checks   = 0;
  int failures = 0;

  alu_share_arbiter_if #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) bus ();

  alu_share_arbiter #(.NREQ(NREQ), .DW(DW), .OPW(OPW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_opcode (alu_opcode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result)
  );

  always_comb begin
    alu_result = '0;
    case (alu_opcode)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = ~alu_a;
      default: alu_result = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench stalled");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    bus.req_valid[i]            = 1'b1;
    bus.req_opcode[i*OPW +: OPW] = op;
    bus.req_a[i*DW +: DW]       = a;
    bus.req_b[i*DW +: DW]       = b;
  endtask

  task automatic clr_req(input int i);
    bus.req_valid[i] = 1'b0;
  endtask

  // Single requester op with resp_ready high: accept at T, response at T+2.
  task automatic do_op(input int i, input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
    logic [NREQ-1:0] oh;
    oh    = '0;
    oh[i] = 1'b1;
    set_req(i, op, a, b);
    #1;
    check("acc_ready", bus.req_ready, oh);
    tick();
    clr_req(i);
    check("exec_ready", bus.req_ready, 0);
    check("exec_rvalid", bus.resp_valid, 0);
    check("alu_op", alu_opcode, op);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    tick();
    check("resp_valid", bus.resp_valid, oh);
    check("resp_data", bus.resp_data, exp);
    check("resp_id", bus.resp_id, i);
`ifdef ALU_OPCODE_CHECK_EN
    check("resp_err", bus.resp_err, (op == 3'b110 || op == 3'b111) ? 1 : 0);
`endif
    tick();
    check("resp_done", bus.resp_valid, 0);
  endtask

  logic [15:0] fair_exp [NREQ] = '{16'h0011, 16'h0111, 16'h0211, 16'h0311};

  initial begin
    rst_n          = 1'b1;
    bus.req_valid  = '0;
    bus.req_opcode = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '1;

    // Reset state, including a request held during reset
    tick();
    bus.req_valid = '1;
    #1;
    check("rst_req_ready", bus.req_ready, 0);
    bus.req_valid = '0;
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_resp_id", bus.resp_id, 0);
    check("rst_alu_op", alu_opcode, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
`ifdef ALU_OPCODE_CHECK_EN
    check("rst_resp_err", bus.resp_err, 0);
`endif
    tick();
    rst_n = 1'b0;
    tick();

    // Opcode coverage, wrap-around and the illegal opcode; ends with ptr = 0
    do_op(0, OP_ADD, 16'h0005, 16'h0003, 16'h0008);
    do_op(2, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF);
    do_op(1, OP_ADD, 16'hFFFF, 16'h0001, 16'h0000);
    do_op(0, OP_AND, 16'hF0F0, 16'hFF00, 16'hF000);
    do_op(2, OP_OR,  16'hF000, 16'h000F, 16'hF00F);
    do_op(1, OP_XOR, 16'hAAAA, 16'h5555, 16'hFFFF);
    do_op(2, OP_NOT, 16'h1234, 16'h0000, 16'hEDCB);
    do_op(3, 3'b111, 16'h1234, 16'h5678, 16'h0000);

    // Fairness: all valid, grants 0,1,2,3,0 exactly 3 cycles apart
    for (int i = 0; i < NREQ; i++) set_req(i, OP_ADD, 16'(i * 256), 16'h0011);
    #1;
    for (int k = 0; k < 5; k++) begin
      check("fair_grant", bus.req_ready, 4'b0001 << (k % NREQ));
      tick();
      check("fair_exec_ready", bus.req_ready, 0);
      tick();
      check("fair_resp_valid", bus.resp_valid, 4'b0001 << (k % NREQ));
      check("fair_resp_id", bus.resp_id, k % NREQ);
      check("fair_resp_data", bus.resp_data, fair_exp[k % NREQ]);
      if (k == 4) bus.req_valid = '0;
      tick();
    end
    check("fair_idle", bus.req_ready, 0);

    // Backpressure on requester 1 while requester 2 waits; ptr = 1 here
    bus.resp_ready = '0;
    set_req(1, OP_XOR, 16'h00FF, 16'h0F0F);
    set_req(2, OP_AND, 16'h0FF0, 16'h00FF);
    #1;
    check("bp_grant", bus.req_ready, 4'b0010);
    tick();
    clr_req(1);
    tick();
    for (int c = 0; c < 5; c++) begin
      check("bp_resp_valid", bus.resp_valid, 4'b0010);
      check("bp_resp_data", bus.resp_data, 16'h0FF0);
      check("bp_resp_id", bus.resp_id, 1);
      check("bp_req_ready", bus.req_ready, 0);
      check("bp_alu_a", alu_a, 16'h00FF);
      bus.resp_ready = 4'b1101;
      tick();
    end
    check("bp_still_resp", bus.resp_valid, 4'b0010);
    bus.resp_ready = 4'b0010;
    tick();
    check("bp_next_grant", bus.req_ready, 4'b0100);
    check("bp_released", bus.resp_valid, 0);
    tick();
    clr_req(2);
    bus.resp_ready = '1;
    tick();
    check("bp2_resp_valid", bus.resp_valid, 4'b0100);
    check("bp2_resp_data", bus.resp_data, 16'h00F0);
    check("bp2_resp_id", bus.resp_id, 2);
    tick();

    // Reset during EXEC aborts the op; ptr = 3 before the reset
    set_req(1, OP_ADD, 16'h0001, 16'h0001);
    #1;
    check("mr_grant", bus.req_ready, 4'b0010);
    tick();
    clr_req(1);
    rst_n = 1'b1;
    #1;
    check("mr_alu_op", alu_opcode, 0);
    check("mr_alu_a", alu_a, 0);
    check("mr_alu_b", alu_b, 0);
    check("mr_resp_data", bus.resp_data, 0);
    check("mr_resp_id", bus.resp_id, 0);
    check("mr_resp_valid", bus.resp_valid, 0);
    check("mr_req_ready", bus.req_ready, 0);
    tick();
    tick();
    check("mr_no_resp", bus.resp_valid, 0);
    rst_n = 1'b0;
    tick();
    check("mr_after_rel", bus.resp_valid, 0);

    // ptr restarts at 0: with 1 and 3 valid, 1 wins, then 3
    set_req(1, OP_ADD, 16'h0001, 16'h0001);
    set_req(3, OP_SUB, 16'h0010, 16'h0001);
    #1;
    check("post_rst_grant", bus.req_ready, 4'b0010);
    tick();
    clr_req(1);
    tick();
    check("post_rst_valid1", bus.resp_valid, 4'b0010);
    check("post_rst_data1", bus.resp_data, 16'h0002);
    tick();
    check("post_rst_grant3", bus.req_ready, 4'b1000);
    tick();
    clr_req(3);
    tick();
    check("post_rst_valid3", bus.resp_valid, 4'b1000);
    check("post_rst_data3", bus.resp_data, 16'h000F);
    check("post_rst_id3", bus.resp_id, 3);
    tick();
    check("final_idle", bus.resp_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
